// File: rtl/echo_buffer_ctrl.sv
// echo_buffer_ctrl: stereo feedback-echo controller around an external single-port delay RAM.
//
// Each accepted stereo sample runs through a fixed five-state sequence:
//   IDLE -> READ -> WAIT -> MIX -> WRITE -> IDLE
// The delayed word is fetched from wr_ptr - delay, halved, and added to the dry input.
// The saturated result goes back into the RAM, so the echo feeds back on itself.
//
// Ports
//   CLOCK_50        sole clock, rising edge
//   RESET_N         synchronous active-low reset
//   Enable          1 = echo applied, 0 = dry pass-through (captured per sample)
//   sample_valid    one-cycle strobe, new stereo sample on leftSampleIn/rightSampleIn
//   leftSampleIn    signed left input sample
//   rightSampleIn   signed right input sample
//   delay_samples   echo delay in samples (0 is treated as 1), captured per sample
//   overrun_clr     clears the sticky overrun flag
//   mem_addr        RAM address
//   mem_we          RAM write enable
//   mem_wdata       RAM write data {left, right}
//   mem_rdata       RAM read data, one cycle after a read address
//   leftSampleOut   processed left sample
//   rightSampleOut  processed right sample
//   out_valid       one-cycle strobe, outputs updated
//   busy            high while a sample is being processed
//   overrun         sticky, a sample_valid arrived while busy and was dropped
module echo_buffer_ctrl #(
  parameter int unsigned ADDR_W = 15
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_N,
  input  logic                     Enable,
  input  logic                     sample_valid,
  input  logic signed [15:0]       leftSampleIn,
  input  logic signed [15:0]       rightSampleIn,
  input  logic        [ADDR_W-1:0] delay_samples,
  input  logic                     overrun_clr,
  output logic        [ADDR_W-1:0] mem_addr,
  output logic                     mem_we,
  output logic        [31:0]       mem_wdata,
  input  logic        [31:0]       mem_rdata,
  output logic signed [15:0]       leftSampleOut,
  output logic signed [15:0]       rightSampleOut,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StMix,
    StWrite
  } state_e;

  state_e state_q, state_d;

  logic signed [15:0]       in_l_q, in_l_d;
  logic signed [15:0]       in_r_q, in_r_d;
  logic                     en_q, en_d;
  logic        [ADDR_W-1:0] delay_q, delay_d;
  logic        [31:0]       rdata_q, rdata_d;
  logic signed [15:0]       out_l_q, out_l_d;
  logic signed [15:0]       out_r_q, out_r_d;
  logic        [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic        [ADDR_W-1:0] fill_q, fill_d;
  logic                     overrun_q, overrun_d;

  logic                     warm_up;
  logic signed [15:0]       wet_l, wet_r;
  logic signed [15:0]       mix_l, mix_r;

  // dry + (wet >>> 1), computed in 17 bits and clamped back to 16.
  function automatic logic signed [15:0] mix_chan(input logic signed [15:0] dry,
                                                  input logic signed [15:0] wet);
    logic signed [16:0] sum;
    sum = {dry[15], dry} + {{2{wet[15]}}, wet[15:1]};
    if (sum[16] != sum[15]) begin
      mix_chan = sum[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      mix_chan = sum[15:0];
    end
  endfunction

  // Until delay_q samples have been written since reset, the read location holds stale data.
  always_comb begin
    warm_up = (fill_q < delay_q);
    wet_l   = warm_up ? 16'sd0 : rdata_q[31:16];
    wet_r   = warm_up ? 16'sd0 : rdata_q[15:0];
    mix_l   = mix_chan(in_l_q, wet_l);
    mix_r   = mix_chan(in_r_q, wet_r);
  end

  always_comb begin
    state_d   = state_q;
    in_l_d    = in_l_q;
    in_r_d    = in_r_q;
    en_d      = en_q;
    delay_d   = delay_q;
    rdata_d   = rdata_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    mem_addr  = wr_ptr_q;
    mem_we    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (sample_valid) begin
          in_l_d  = leftSampleIn;
          in_r_d  = rightSampleIn;
          en_d    = Enable;
          delay_d = (delay_samples == '0) ? ADDR_W'(1) : delay_samples;
          state_d = StRead;
        end
      end
      StRead: begin
        // Modular subtraction wraps naturally at ADDR_W bits.
        mem_addr = wr_ptr_q - delay_q;
        state_d  = StWait;
      end
      StWait: begin
        rdata_d = mem_rdata;
        state_d = StMix;
      end
      StMix: begin
        out_l_d = en_q ? mix_l : in_l_q;
        out_r_d = en_q ? mix_r : in_r_q;
        state_d = StWrite;
      end
      StWrite: begin
        mem_we    = 1'b1;
        out_valid = 1'b1;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        fill_d    = (fill_q == '1) ? fill_q : fill_q + ADDR_W'(1);
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Set wins over clear so a drop in the same cycle is never lost.
    overrun_d = (overrun_q & ~overrun_clr) | (sample_valid & (state_q != StIdle));
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      in_l_q    <= '0;
      in_r_q    <= '0;
      en_q      <= 1'b0;
      delay_q   <= ADDR_W'(1);
      rdata_q   <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_l_q    <= in_l_d;
      in_r_q    <= in_r_d;
      en_q      <= en_d;
      delay_q   <= delay_d;
      rdata_q   <= rdata_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      overrun_q <= overrun_d;
    end
  end

  assign mem_wdata      = {out_l_q, out_r_q};
  assign leftSampleOut  = out_l_q;
  assign rightSampleOut = out_r_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_echo_buffer_ctrl.sv
// Bench for echo_buffer_ctrl with ADDR_W=4: a transaction-level echo model predicts every
// output cycle by cycle, and a few literal sequences pin the model itself.
module tb_echo_buffer_ctrl;

  localparam int unsigned AW    = 4;
  localparam int          Depth = 16;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N;
  logic          Enable;
  logic          sample_valid;
  logic [15:0]   leftSampleIn;
  logic [15:0]   rightSampleIn;
  logic [AW-1:0] delay_samples;
  logic          overrun_clr;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [15:0]   leftSampleOut;
  logic [15:0]   rightSampleOut;
  logic          out_valid;
  logic          busy;
  logic          overrun;

  always #10 CLOCK_50 = ~CLOCK_50;

  echo_buffer_ctrl #(.ADDR_W(AW)) dut (
    .CLOCK_50      (CLOCK_50),
    .RESET_N       (RESET_N),
    .Enable        (Enable),
    .sample_valid  (sample_valid),
    .leftSampleIn  (leftSampleIn),
    .rightSampleIn (rightSampleIn),
    .delay_samples (delay_samples),
    .overrun_clr   (overrun_clr),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .leftSampleOut (leftSampleOut),
    .rightSampleOut(rightSampleOut),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  // Synchronous single-port RAM, filled with random junk on the first edge.
  logic [31:0] ram [Depth];
  bit          ram_init = 1'b0;
  always @(posedge CLOCK_50) begin
    if (!ram_init) begin
      for (int i = 0; i < Depth; i++) ram[i] <= $urandom;
      ram_init <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] w16(input int v);
    logic [15:0] t;
    t = 16'(v);
    return {16'h0, t};
  endfunction

  // Reference model: a sample's result is computed when it is accepted; the cycle
  // counter ph only says how many cycles remain until it appears (0 = free).
  int          ph = 0;
  int          wp = 0;
  int          fill = 0;
  int          m_d = 1;
  logic [31:0] mm [Depth];
  logic [15:0] e_l = '0, e_r = '0, p_l = '0, p_r = '0;
  bit          e_ov = 1'b0;

  function automatic logic [15:0] mix(input logic [15:0] dry, input logic [15:0] wet,
                                      input bit warm, input bit en);
    int s;
    int dl;
    if (!en) return dry;
    dl = warm ? 0 : int'($signed(wet));
    s  = int'($signed(dry)) + (dl >>> 1);
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic model_step();
    logic [31:0] w;
    bit          warm;
    if (!RESET_N) begin
      ph = 0; wp = 0; fill = 0; e_l = '0; e_r = '0; e_ov = 1'b0;
      return;
    end
    e_ov = (e_ov && !overrun_clr) || (sample_valid && ph != 0);
    case (ph)
      0: if (sample_valid) begin
        m_d  = (delay_samples == 0) ? 1 : int'(delay_samples);
        warm = fill < m_d;
        w    = warm ? 32'h0 : mm[(wp - m_d + Depth) % Depth];
        p_l  = mix(leftSampleIn, w[31:16], warm, Enable);
        p_r  = mix(rightSampleIn, w[15:0], warm, Enable);
        ph   = 1;
      end
      1, 2: ph++;
      3: begin e_l = p_l; e_r = p_r; ph = 4; end
      default: begin
        mm[wp] = {e_l, e_r};
        wp     = (wp + 1) % Depth;
        fill   = (fill < Depth - 1) ? fill + 1 : Depth - 1;
        ph     = 0;
      end
    endcase
  endtask

  bit          chk_en = 1'b0;
  int          we_count = 0;
  logic [15:0] obs_l[$];
  logic [15:0] obs_r[$];

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, ph != 0});
      check("out_valid", {31'b0, out_valid}, {31'b0, ph == 4});
      check("mem_we", {31'b0, mem_we}, {31'b0, ph == 4});
      check("overrun", {31'b0, overrun}, {31'b0, e_ov});
      check("left_out", {16'h0, leftSampleOut}, {16'h0, e_l});
      check("right_out", {16'h0, rightSampleOut}, {16'h0, e_r});
      if (ph == 0 || ph == 4) check("wr_addr", {28'h0, mem_addr}, 32'(wp));
      if (ph == 1) check("rd_addr", {28'h0, mem_addr}, 32'((wp - m_d + Depth) % Depth));
      if (ph == 4) check("wdata", mem_wdata, {e_l, e_r});
      if (out_valid) begin
        obs_l.push_back(leftSampleOut);
        obs_r.push_back(rightSampleOut);
      end
      if (mem_we) we_count++;
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic send(input int l, input int r, input bit en, input int d);
    leftSampleIn  = 16'(l);
    rightSampleIn = 16'(r);
    Enable        = en;
    delay_samples = AW'(d);
    sample_valid  = 1'b1;
    tick();
    sample_valid  = 1'b0;
  endtask

  task automatic check_obs(input string name, input int idx, input int l, input int r);
    check({name, "_count"}, {31'b0, obs_l.size() > idx}, 32'd1);
    if (obs_l.size() > idx) begin
      check({name, "_l"}, {16'h0, obs_l[idx]}, w16(l));
      check({name, "_r"}, {16'h0, obs_r[idx]}, w16(r));
    end
  endtask

  task automatic check_latency();
    int n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd3);
  endtask

  int we0;
  int n_obs;

  initial begin
    RESET_N = 1'b0; Enable = 1'b0; sample_valid = 1'b0; leftSampleIn = '0;
    rightSampleIn = '0; delay_samples = '0; overrun_clr = 1'b0;
    for (int i = 0; i < Depth; i++) mm[i] = '0;
    idle(2);
    chk_en = 1'b1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_out", {16'h0, leftSampleOut}, 32'd0);

    // Constant 1000 with delay 2: 1000,1000,1500,1500,1750.
    do_reset();
    obs_l.delete(); obs_r.delete();
    repeat (5) begin send(1000, 1000, 1'b1, 2); idle(7); end
    check_obs("d2_0", 0, 1000, 1000);
    check_obs("d2_1", 1, 1000, 1000);
    check_obs("d2_2", 2, 1500, 1500);
    check_obs("d2_3", 3, 1500, 1500);
    check_obs("d2_4", 4, 1750, 1750);

    // Saturation, with the delayed word written by a dry pass-through sample.
    do_reset();
    obs_l.delete(); obs_r.delete();
    send(8000, -8000, 1'b0, 1); idle(7);
    send(30000, -30000, 1'b1, 1);
    check_latency();
    idle(5);
    check_obs("dry", 0, 8000, -8000);
    check_obs("sat", 1, 32767, -32768);

    // Drop two cycles after an accepted sample; set and clear together keep the flag.
    do_reset();
    we0 = we_count;
    send(100, 200, 1'b1, 3); idle(1);
    sample_valid = 1'b1; tick(); sample_valid = 1'b0;
    idle(8);
    check("drop_writes", 32'(we_count - we0), 32'd1);
    check("ovr_set", {31'b0, overrun}, 32'd1);
    send(1, 1, 1'b1, 3);
    overrun_clr = 1'b1; sample_valid = 1'b1; tick();
    overrun_clr = 1'b0; sample_valid = 1'b0;
    check("ovr_set_clr", {31'b0, overrun}, 32'd1);
    idle(6);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    check("ovr_clr", {31'b0, overrun}, 32'd0);

    // Reset during MIX: no write, outputs cleared, next sample sees warm-up.
    do_reset();
    send(1111, 2222, 1'b1, 1); idle(7);
    send(3000, 3000, 1'b1, 1); idle(2);
    we0 = we_count; n_obs = obs_l.size();
    RESET_N = 1'b0; tick(); RESET_N = 1'b1;
    check("rst_mix_l", {16'h0, leftSampleOut}, 32'd0);
    check("rst_mix_busy", {31'b0, busy}, 32'd0);
    idle(4);
    check("rst_mix_we", 32'(we_count - we0), 32'd0);
    check("rst_mix_valid", 32'(obs_l.size() - n_obs), 32'd0);
    send(500, -500, 1'b1, 1); idle(7);
    check_obs("warm", n_obs, 500, -500);

    // delay 0 acts as delay 1.
    do_reset();
    obs_l.delete(); obs_r.delete();
    send(1000, 1000, 1'b1, 0); idle(7);
    send(1000, -1000, 1'b1, 0); idle(7);
    check_obs("d0", 1, 1500, -500);

    // Delay 15 across the pointer wrap: sample 0 echoes into sample 15.
    do_reset();
    obs_l.delete(); obs_r.delete();
    send(2000, -2000, 1'b1, 15); idle(7);
    for (int k = 1; k < 20; k++) begin
      if (k == 15) send(0, 0, 1'b1, 15);
      else send(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                1'b1, 15);
      idle(7);
    end
    check_obs("wrap15", 15, 1000, -1000);

    // Random traffic, including strobes while busy and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      sample_valid  = ($urandom_range(0, 3) == 0);
      Enable        = ($urandom_range(0, 4) != 0);
      leftSampleIn  = 16'($urandom);
      rightSampleIn = 16'($urandom);
      delay_samples = AW'($urandom_range(0, 15));
      overrun_clr   = ($urandom_range(0, 15) == 0);
      RESET_N       = ($urandom_range(0, 199) != 0);
      tick();
    end
    sample_valid = 1'b0; overrun_clr = 1'b0; RESET_N = 1'b1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
